wbr_test_sequencer: RTL and testbench
=====================================

// Module: wbr_test_sequencer
// PURPOSE
//  Sequences the wrapper boundary register (WBR) chains of one wrapped core during IEEE 1500 tests.
//  Per test request it generates the wse_*/hold_* controls for the input-cell and output-cell groups.
//  The generated sequence is: serial shift, then apply (hold), then a 1-cycle capture.
//  Sits between the wrapper instruction logic (start/mode) and the WBR cell instances.
//  Cell encoding: wse=1 shift; wse=0,hold=0 capture/functional; wse=0,hold=1 hold.
// PARAMETERS
//  CHAIN_LEN  9   WBR length in cells; used when shift_len==0
//  CNT_W      4   shift counter width; must satisfy 2**CNT_W >= CHAIN_LEN
//  APPLY_CYC  2   cycles spent in APPLY (>=1)
// PORTS
//  CLK           in   1      rising-edge clock
//  resetn        in   1      synchronous, active-low reset
//  test_mode     in   1      1 = wrapper in test mode; selects IDLE hold behaviour
//  start         in   1      request one sequence; sampled only in IDLE
//  mode          in   2      01 INTEST, 10 EXTEST; 00/11 illegal
//  shift_len     in   CNT_W  shift cycles for this sequence; 0 means CHAIN_LEN
//  abort         in   1      terminate the current sequence
//  wse_inputs    out  1      shift enable, input-cell group
//  hold_inputs   out  1      hold, input-cell group
//  wse_outputs   out  1      shift enable, output-cell group
//  hold_outputs  out  1      hold, output-cell group
//  busy          out  1      1 in every state except IDLE
//  done          out  1      1-cycle pulse at end of a completed sequence
//  err           out  1      1-cycle pulse on illegal mode or abort
// BEHAVIOUR
//  - All outputs are registered. resetn=0 at an edge: state<=IDLE, every output <=0, counters <=0.
//  - States: IDLE -> SHIFT -> APPLY -> CAPTURE -> DONE -> IDLE.
//  - IDLE: wse_*=0, hold_*=test_mode, i.e. functional when 0, preserve contents when 1.
//  - start=1 in IDLE with legal mode: latch mode and L (shift_len, or CHAIN_LEN if 0); go to SHIFT next cycle.
//  - start=1 in IDLE with illegal mode: err=1 for one cycle; stay IDLE.
//  - start in any other state: ignored. It is not queued.
//  - SHIFT lasts exactly L cycles: both wse_*=1, both hold_*=0.
//    Counter loads L-1 and decrements; the state exits when the counter is 0.
//  - APPLY lasts exactly APPLY_CYC cycles: both wse_*=0, both hold_*=1.
//  - CAPTURE lasts 1 cycle, with wse_*=0:
//    INTEST: hold_inputs=1, hold_outputs=0 (output cells capture the core response).
//    EXTEST: hold_inputs=0, hold_outputs=1 (input cells capture the pins).
//  - DONE lasts 1 cycle: done=1, both hold_*=1, wse_*=0; then IDLE.
//  - busy=1 from the cycle after start is accepted through the DONE cycle.
//    Busy length is L + APPLY_CYC + 2 cycles.
//  - abort=1 in any non-IDLE state:
//    next cycle IDLE-valued outputs, err=1, done=0; the counter is cleared.
//    abort in IDLE has no effect.
//  - Simultaneous abort and the last SHIFT cycle: abort wins.
//  - Simultaneous start and resetn=0: reset wins.
//  - Reset mid-sequence: IDLE with all outputs 0 next cycle. The sequence is not resumed.
//  - mode and L are frozen while busy; input changes are ignored until IDLE.
// TESTING
//  1. Reset: hold resetn=0 for 2 cycles -> all outputs 0. Release with test_mode=1 -> hold_*=1 one cycle later.
//  2. INTEST: start, mode=01, shift_len=0 -> wse_*=1 for 9 cycles, hold_*=1 for 2, then CAPTURE with hold_outputs=0/hold_inputs=1; done at cycle 13; busy=1 for 13 cycles.
//  3. EXTEST: start, mode=10, shift_len=3 -> 3 shift cycles; CAPTURE with hold_inputs=0/hold_outputs=1; done at cycle 7.
//  4. Abort: abort at shift cycle 4 of 9 -> next cycle busy=0, err=1, wse_*=0, done never pulses.
//  5. Illegal and busy: start with mode=00 -> err pulse, busy stays 0. start during APPLY -> ignored; sequence length unchanged.
//  6. Reset mid-APPLY: resetn=0 -> next cycle all outputs 0. A new start after release runs a full sequence.

Source files
------------

// File: rtl/wbr_test_sequencer.sv
// ---------------------------------------------------------------------------
// wbr_test_sequencer
//
// Sequences the wrapper boundary register (WBR) chains of one wrapped core.
// Each accepted test request produces a serial shift, an apply (hold) phase,
// a single capture cycle and a one-cycle done pulse. The control outputs
// drive the input-cell and output-cell groups of the WBR.
//
// Cell control encoding:
//   wse=1            shift
//   wse=0, hold=0    capture / functional
//   wse=0, hold=1    hold
//
// Ports:
//   CLK           rising-edge clock
//   resetn        synchronous, active-low reset
//   test_mode     1 = wrapper in test mode (IDLE holds the cell contents)
//   start         request one sequence; sampled only in IDLE
//   mode          01 INTEST, 10 EXTEST; 00/11 are illegal
//   shift_len     shift cycles for this sequence; 0 selects CHAIN_LEN
//   abort         terminate the current sequence
//   wse_inputs    shift enable, input-cell group
//   hold_inputs   hold, input-cell group
//   wse_outputs   shift enable, output-cell group
//   hold_outputs  hold, output-cell group
//   busy          high in every state except IDLE
//   done          one-cycle pulse at the end of a completed sequence
//   err           one-cycle pulse on illegal mode or abort
// ---------------------------------------------------------------------------
module wbr_test_sequencer #(
    parameter int CHAIN_LEN = 9,
    parameter int CNT_W     = 4,
    parameter int APPLY_CYC = 2
) (
    input  logic             CLK,
    input  logic             resetn,
    input  logic             test_mode,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] shift_len,
    input  logic             abort,
    output logic             wse_inputs,
    output logic             hold_inputs,
    output logic             wse_outputs,
    output logic             hold_outputs,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int APPLY_W = (APPLY_CYC > 1) ? $clog2(APPLY_CYC) : 1;
    localparam logic [CNT_W-1:0]   CHAIN_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [APPLY_W-1:0] APPLY_LAST = APPLY_W'(APPLY_CYC - 1);
    localparam logic [1:0] MODE_INTEST = 2'b01;
    localparam logic [1:0] MODE_EXTEST = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_APPLY,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [APPLY_W-1:0] apply_cnt_reg, apply_cnt_next;
    logic [1:0]         mode_reg, mode_next;

    logic wse_next;
    logic hold_in_next;
    logic hold_out_next;
    logic busy_next;
    logic done_next;
    logic err_next;

    logic mode_legal;
    assign mode_legal = (mode == MODE_INTEST) || (mode == MODE_EXTEST);

    // Next state, counters and the registered-output values. Outputs are
    // decoded from the state being entered so that they line up with it.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        apply_cnt_next = apply_cnt_reg;
        mode_next      = mode_reg;
        err_next       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (mode_legal) begin
                        state_next = S_SHIFT;
                        mode_next  = mode;
                        // Counter holds "remaining cycles minus one".
                        cnt_next   = (shift_len == '0) ? CHAIN_LAST
                                                       : shift_len - CNT_W'(1);
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (cnt_reg == '0) begin
                    state_next     = S_APPLY;
                    apply_cnt_next = APPLY_LAST;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            S_APPLY: begin
                if (apply_cnt_reg == '0) begin
                    state_next = S_CAPTURE;
                end else begin
                    apply_cnt_next = apply_cnt_reg - APPLY_W'(1);
                end
            end
            S_CAPTURE: state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase

        // Abort overrides every transition, including the last shift cycle.
        if (abort && (state_reg != S_IDLE)) begin
            state_next     = S_IDLE;
            cnt_next       = '0;
            apply_cnt_next = '0;
            err_next       = 1'b1;
        end

        wse_next      = 1'b0;
        hold_in_next  = 1'b0;
        hold_out_next = 1'b0;
        busy_next     = 1'b1;
        done_next     = 1'b0;
        case (state_next)
            S_IDLE: begin
                hold_in_next  = test_mode;
                hold_out_next = test_mode;
                busy_next     = 1'b0;
            end
            S_SHIFT: wse_next = 1'b1;
            S_APPLY: begin
                hold_in_next  = 1'b1;
                hold_out_next = 1'b1;
            end
            S_CAPTURE: begin
                // The group that captures releases its hold.
                hold_in_next  = (mode_next == MODE_INTEST);
                hold_out_next = (mode_next == MODE_EXTEST);
            end
            S_DONE: begin
                hold_in_next  = 1'b1;
                hold_out_next = 1'b1;
                done_next     = 1'b1;
            end
            default: busy_next = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            apply_cnt_reg <= '0;
            mode_reg      <= '0;
            wse_inputs    <= 1'b0;
            hold_inputs   <= 1'b0;
            wse_outputs   <= 1'b0;
            hold_outputs  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            apply_cnt_reg <= apply_cnt_next;
            mode_reg      <= mode_next;
            wse_inputs    <= wse_next;
            hold_inputs   <= hold_in_next;
            wse_outputs   <= wse_next;
            hold_outputs  <= hold_out_next;
            busy          <= busy_next;
            done          <= done_next;
            err           <= err_next;
        end
    end

endmodule

// File: tb/tb_wbr_test_sequencer.sv
// ---------------------------------------------------------------------------
// tb_wbr_test_sequencer
//
// Self-checking bench for wbr_test_sequencer: a cycle table with constant
// expectations, hand-written multi-cycle sequences, and a randomized phase
// compared against a plan-queue reference model.
// Output vector packing: {wse_i, hold_i, wse_o, hold_o, busy, done, err}.
// ---------------------------------------------------------------------------
module tb_wbr_test_sequencer;

    localparam int CHAIN_LEN = 9;
    localparam int CNT_W     = 4;
    localparam int APPLY_CYC = 2;

    logic             CLK = 1'b0;
    logic             resetn = 1'b0;
    logic             test_mode = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [CNT_W-1:0] shift_len = '0;
    logic             abort = 1'b0;
    logic wse_inputs, hold_inputs, wse_outputs, hold_outputs, busy, done, err;

    wbr_test_sequencer #(
        .CHAIN_LEN(CHAIN_LEN), .CNT_W(CNT_W), .APPLY_CYC(APPLY_CYC)
    ) dut (
        .CLK(CLK), .resetn(resetn), .test_mode(test_mode), .start(start),
        .mode(mode), .shift_len(shift_len), .abort(abort),
        .wse_inputs(wse_inputs), .hold_inputs(hold_inputs),
        .wse_outputs(wse_outputs), .hold_outputs(hold_outputs),
        .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0] got;
    logic [6:0] exp_m;

    // ---------------- reference model ----------------
    // A started sequence is expanded up front into the list of output
    // vectors it will produce; each clock pops one.
    logic [6:0] plan[$];
    logic       m_busy = 1'b0;

    function automatic logic [6:0] idle_vec(input logic tm);
        return {1'b0, tm, 1'b0, tm, 3'b000};
    endfunction

    task automatic model_step(input logic rn, tm, st, input logic [1:0] md,
                              input logic [3:0] sl, input logic ab,
                              output logic [6:0] e);
        int len;
        if (!rn) begin
            plan.delete();
            e = '0;
        end else if (m_busy) begin
            if (ab) begin
                plan.delete();
                e = idle_vec(tm) | 7'b0000001;
            end else if (plan.size() > 0) begin
                e = plan.pop_front();
            end else begin
                e = idle_vec(tm);
            end
        end else if (st) begin
            if (md == 2'b01 || md == 2'b10) begin
                len = (sl == 0) ? CHAIN_LEN : int'(sl);
                for (int i = 0; i < len; i++)       plan.push_back(7'b1010100);
                for (int i = 0; i < APPLY_CYC; i++) plan.push_back(7'b0101100);
                plan.push_back((md == 2'b01) ? 7'b0100100 : 7'b0001100);
                plan.push_back(7'b0101110);
                e = plan.pop_front();
            end else begin
                e = idle_vec(tm) | 7'b0000001;
            end
        end else begin
            e = idle_vec(tm);
        end
        m_busy = e[2];
    endtask

    task automatic tick(input logic rn, tm, st, input logic [1:0] md,
                        input logic [3:0] sl, input logic ab);
        resetn = rn; test_mode = tm; start = st; mode = md;
        shift_len = sl; abort = ab;
        @(posedge CLK);
        #1;
        model_step(rn, tm, st, md, sl, ab, exp_m);
        got = {wse_inputs, hold_inputs, wse_outputs, hold_outputs, busy, done, err};
    endtask

    task automatic check(input string name, input logic [6:0] g, input logic [6:0] e);
        n_checks++;
        if (g === e) n_pass++;
        else $display("FAIL %s: got=%b expected=%b", name, g, e);
    endtask

    task automatic check_int(input string name, input int g, input int e);
        n_checks++;
        if (g == e) n_pass++;
        else $display("FAIL %s: got=%0d expected=%0d", name, g, e);
    endtask

    // ---------------- table ----------------
    typedef struct {
        logic       rn, tm, st;
        logic [1:0] md;
        logic [3:0] sl;
        logic       ab;
        logic [6:0] exp_v;
    } vec_t;

    localparam int NVEC = 26;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic rn, tm, st, input logic [1:0] md,
                                input logic [3:0] sl, input logic ab,
                                input logic [6:0] ev);
        vec_t v;
        v.rn = rn; v.tm = tm; v.st = st; v.md = md; v.sl = sl; v.ab = ab;
        v.exp_v = ev;
        return v;
    endfunction

    // ---------------- multi-cycle sequence runner ----------------
    // Cycle 1 is the first cycle after the accepting edge. start/abort are
    // raised during the cycle numbered start_at/abort_at.
    task automatic run_seq(input string name, input logic [1:0] md, input logic [3:0] sl,
                           input int abort_at, input int start_at,
                           output int nbusy, output int nwse, output int done_cyc,
                           output int nerr, output logic [1:0] cap);
        int cyc;
        nbusy = 0; nwse = 0; done_cyc = 0; nerr = 0; cap = 2'bxx;
        cyc = 1;
        tick(1, 1, 1, md, sl, 0);
        check({name, " c1"}, got, exp_m);
        forever begin
            if (busy) nbusy++;
            if (wse_inputs) nwse++;
            if (done) done_cyc = cyc;
            if (err) nerr++;
            if (busy && !wse_inputs && !done && !(hold_inputs && hold_outputs))
                cap = {hold_inputs, hold_outputs};
            if (!busy) break;
            if (cyc >= 40) begin
                check_int({name, " timeout"}, cyc, 0);
                break;
            end
            tick(1, 1, cyc == start_at, 2'b01, 4'd5, cyc == abort_at);
            cyc++;
            check($sformatf("%s c%0d", name, cyc), got, exp_m);
        end
        $display("seq %s: busy=%0d wse=%0d done_at=%0d err=%0d cap=%b",
                 name, nbusy, nwse, done_cyc, nerr, cap);
    endtask

    initial begin
        int nb, nw, dc, ne;
        logic [1:0] cp;
        int rn_i, starts;
        logic rtm;

        // cycle table: inputs before an edge, outputs expected after it
        tbl[0]  = mk(0,1,1,2'b01,4'd0,0, 7'b0000000); // reset beats start
        tbl[1]  = mk(0,1,0,2'b00,4'd0,0, 7'b0000000);
        tbl[2]  = mk(1,1,0,2'b00,4'd0,0, 7'b0101000); // release, test_mode holds
        tbl[3]  = mk(1,0,0,2'b00,4'd0,0, 7'b0000000); // functional
        tbl[4]  = mk(1,1,1,2'b00,4'd0,0, 7'b0101001); // illegal 00
        tbl[5]  = mk(1,1,1,2'b11,4'd0,0, 7'b0101001); // illegal 11
        tbl[6]  = mk(1,1,0,2'b00,4'd0,0, 7'b0101000);
        tbl[7]  = mk(1,1,1,2'b10,4'd3,0, 7'b1010100); // EXTEST L=3
        tbl[8]  = mk(1,1,1,2'b01,4'd5,0, 7'b1010100); // start ignored
        tbl[9]  = mk(1,1,0,2'b00,4'd0,0, 7'b1010100);
        tbl[10] = mk(1,1,0,2'b00,4'd0,0, 7'b0101100); // apply
        tbl[11] = mk(1,1,1,2'b01,4'd1,0, 7'b0101100);
        tbl[12] = mk(1,1,0,2'b00,4'd0,0, 7'b0001100); // EXTEST capture
        tbl[13] = mk(1,1,0,2'b00,4'd0,0, 7'b0101110); // done
        tbl[14] = mk(1,1,0,2'b00,4'd0,0, 7'b0101000);
        tbl[15] = mk(1,0,0,2'b00,4'd0,1, 7'b0000000); // abort in IDLE: no err
        tbl[16] = mk(1,0,1,2'b01,4'd1,0, 7'b1010100); // INTEST L=1
        tbl[17] = mk(1,0,0,2'b00,4'd0,0, 7'b0101100);
        tbl[18] = mk(1,0,0,2'b00,4'd0,0, 7'b0101100);
        tbl[19] = mk(1,0,0,2'b00,4'd0,0, 7'b0100100); // INTEST capture
        tbl[20] = mk(1,0,0,2'b00,4'd0,0, 7'b0101110);
        tbl[21] = mk(1,0,0,2'b00,4'd0,0, 7'b0000000);
        tbl[22] = mk(1,0,1,2'b01,4'd2,0, 7'b1010100); // L=2
        tbl[23] = mk(1,0,0,2'b00,4'd0,0, 7'b1010100); // last shift cycle
        tbl[24] = mk(1,0,0,2'b00,4'd0,1, 7'b0000001); // abort wins
        tbl[25] = mk(1,0,0,2'b00,4'd0,0, 7'b0000000);

        for (int i = 0; i < NVEC; i++) begin
            tick(tbl[i].rn, tbl[i].tm, tbl[i].st, tbl[i].md, tbl[i].sl, tbl[i].ab);
            $display("vec %0d: rn=%b tm=%b st=%b md=%b sl=%0d ab=%b -> %b",
                     i, tbl[i].rn, tbl[i].tm, tbl[i].st, tbl[i].md, tbl[i].sl,
                     tbl[i].ab, got);
            check($sformatf("vec%0d", i), got, tbl[i].exp_v);
        end

        // INTEST, full chain
        run_seq("intest_full", 2'b01, 4'd0, 0, 0, nb, nw, dc, ne, cp);
        check_int("intest busy", nb, 13);
        check_int("intest wse", nw, 9);
        check_int("intest done_at", dc, 13);
        check_int("intest cap", int'(cp), 2);

        // EXTEST, 3 shift cycles
        run_seq("extest_3", 2'b10, 4'd3, 0, 0, nb, nw, dc, ne, cp);
        check_int("extest busy", nb, 7);
        check_int("extest wse", nw, 3);
        check_int("extest done_at", dc, 7);
        check_int("extest cap", int'(cp), 1);

        // abort in shift cycle 4 of 9
        run_seq("abort_shift4", 2'b01, 4'd0, 4, 0, nb, nw, dc, ne, cp);
        check_int("abort busy", nb, 4);
        check_int("abort done", dc, 0);
        check_int("abort err", ne, 1);
        check_int("abort wse_after", int'(wse_inputs), 0);

        // start during APPLY is ignored
        run_seq("start_in_apply", 2'b10, 4'd3, 0, 4, nb, nw, dc, ne, cp);
        check_int("ign busy", nb, 7);
        check_int("ign done_at", dc, 7);
        check_int("ign cap", int'(cp), 1);

        // reset mid-APPLY, then a full sequence
        tick(1, 1, 1, 2'b01, 4'd2, 0);
        for (int i = 0; i < 3; i++) tick(1, 1, 0, 2'b00, 4'd0, 0);
        check("mid apply", got, 7'b0101100);
        tick(0, 1, 1, 2'b01, 4'd0, 0);
        check("reset mid apply", got, 7'b0000000);
        tick(1, 1, 0, 2'b00, 4'd0, 0);
        check("after release", got, 7'b0101000);
        run_seq("after_reset", 2'b01, 4'd0, 0, 0, nb, nw, dc, ne, cp);
        check_int("after_reset busy", nb, 13);
        check_int("after_reset done_at", dc, 13);

        // randomized phase against the reference model
        starts = 0;
        rtm = 1'b1;
        for (int c = 0; c < 800; c++) begin
            logic rn, st, ab;
            logic [1:0] md;
            logic [3:0] sl;
            rn_i = int'($urandom_range(0, 59));
            rn = (rn_i != 0);
            if ($urandom_range(0, 15) == 0) rtm = ~rtm;
            st = ($urandom_range(0, 2) == 0);
            md = 2'($urandom_range(0, 3));
            sl = 4'($urandom_range(0, 15));
            ab = ($urandom_range(0, 24) == 0);
            if (rn && st && !m_busy && (md == 2'b01 || md == 2'b10)) begin
                starts++;
                $display("rand start %0d at cycle %0d: mode=%b len=%0d", starts, c, md, sl);
            end
            tick(rn, rtm, st, md, sl, ab);
            check($sformatf("rand c%0d", c), got, exp_m);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
